counter_prog: RTL
=================

Name: counter_prog

Overview:
- Parametrised up/down counter; successor of the fixed 16-bit up counter.
- Adds programmable terminal value (modulo term_val+1), direction control, parallel load, and three modes: wrap, saturate, one-shot.
- Used as a general event, timer and tick source across the design.
- Terminal-count output stays combinational, so counters can be cascaded.

Parameters:
- WIDTH, 16, counter width in bits (2..32).
- RESET_VAL, 0, value of count after reset (WIDTH bits).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- count_en  in  1  step enable, one step per cycle while high.
- up_dn  in  1  1 = count up, 0 = count down; sampled every cycle.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value loaded on load.
- term_val  in  WIDTH  programmable terminal value; held stable during operation.
- mode  in  2  0 = WRAP, 1 = SATURATE, 2 = ONESHOT, 3 = reserved (behaves as WRAP).
- start  in  1  one-shot start strobe; ignored in other modes.
- count  out  WIDTH  current count, registered.
- count_tc  out  1  terminal-count indicator, combinational.
- done  out  1  one-shot complete, registered.

Behaviour:
- Reset: count = RESET_VAL, state = IDLE, done = 0. Reset wins over every other input.
- Priority below reset: load > start > step.
- Terminal target: T = term_val when counting up; T = 0 when counting down.
- Step enable: en_eff = count_en (or the prescaler tick when the optional feature is built in), gated by active.
- active = 1 in WRAP and SATURATE. In ONESHOT, active = 1 only in state RUN.
- count_tc = en_eff & active & (count == T). No register, no added latency.
- Step when count != T: count ± 1, modulo 2^WIDTH.
  - count above term_val while counting up runs to 2^WIDTH-1, wraps to 0, then continues.
  - Equality compare only, no clamping.
- Step when count == T:
  - WRAP: up reloads 0; down reloads term_val.
  - SATURATE: count holds; count_tc stays high on every enabled cycle.
  - ONESHOT: count holds at T; state goes RUN -> DONE.
- Load: count = load_val next cycle. The step is suppressed that cycle. FSM state is unchanged.
- One-shot FSM:
  - States are IDLE, RUN, DONE.
  - IDLE or DONE, start=1 -> RUN. Count is preset to 0 (up) or term_val (down). done clears.
  - RUN, start=1 -> restart with the same preset.
  - RUN, enabled step at T -> DONE. done = 1 from the next cycle and stays set until start or reset.
  - DONE ignores count_en.
- Mode change: if mode != ONESHOT, state is forced to IDLE and done = 0 next cycle.
- term_val = 0: every enabled step is terminal. Up/WRAP holds at 0 with count_tc high each enabled cycle.
- up_dn change mid-count: the new direction applies from that cycle. T is recomputed combinationally.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- With the macro:
  - Adds input presc_div [7:0].
  - An internal 8-bit prescaler counts count_en cycles.
  - en_eff pulses once per presc_div+1 count_en cycles; presc_div = 0 gives en_eff = count_en.
  - The prescaler clears on reset, load and start.
  - count_tc uses en_eff.
- Without the macro: no port, no prescaler, en_eff = count_en.

Decomposition:
- Package counter_pkg holds:
  - mode enum: CNT_WRAP, CNT_SAT, CNT_ONESHOT.
  - FSM state enum: ST_IDLE, ST_RUN, ST_DONE.
  - PRESC_W = 8.
- One sub-module, counter_prescaler (clock, reset, clr, en_in, div, tick). It is instantiated only under COUNTER_PRESCALE_EN.

Test Plan:
- WRAP, WIDTH=16, term_val=0xFFFF, up, en held -> count 0xFFFE, 0xFFFF (count_tc=1), then 0x0000. Drop en at 0xFFFF -> count_tc=0.
- WRAP, term_val=9, down from load_val=2 -> 2, 1, 0 (count_tc=1), 9, 8. Assert load=1 and reset=1 together -> count=RESET_VAL.
- SATURATE, term_val=5, up, en held 10 cycles from 0 -> count holds 5; count_tc=1 on every cycle from the 6th on.
- ONESHOT, term_val=3, up, start then en held -> 0,1,2,3 with one count_tc pulse; done=1 next cycle. Further en leaves count at 3. A second start clears done and restarts from 0.
- ONESHOT mid-RUN: switch mode to WRAP -> done=0, state IDLE, counting continues in WRAP. Apply load=1 and start=1 in the same cycle -> load wins, count=load_val.
- With COUNTER_PRESCALE_EN, presc_div=3, WRAP, term_val=1 -> count advances once per 4 count_en cycles. A gap in count_en stretches the period accordingly.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and constants for the programmable counter
package counter_pkg;

    localparam int unsigned PRESC_W = 8;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_SAT     = 2'd1,
        CNT_ONESHOT = 2'd2
    } cnt_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cnt_state_e;

    // The reserved encoding falls back to wrap behaviour.
    function automatic cnt_mode_e decode_mode(input logic [1:0] raw);
        cnt_mode_e m;
        case (raw)
            2'd1:    m = CNT_SAT;
            2'd2:    m = CNT_ONESHOT;
            default: m = CNT_WRAP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - divides the step enable, one tick per div+1 enabled cycles
module counter_prescaler
    import counter_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clr,
    input  logic               en_in,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;

    // >= rather than == so a divider lowered mid-count still ticks promptly.
    always_comb begin
        tick  = en_in && (cnt_q >= div);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en_in) begin
            cnt_d = tick ? '0 : cnt_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_prog.sv
// rtl/counter_prog.sv - up/down counter with terminal value, load and wrap/saturate/one-shot modes; COUNTER_PRESCALE_EN adds a step prescaler
module counter_prog
    import counter_pkg::*;
#(
    parameter int unsigned       WIDTH     = 16,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               count_en,
    input  logic               up_dn,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [WIDTH-1:0]   term_val,
    input  logic [1:0]         mode,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESC_W-1:0] presc_div,
`endif
    input  logic               start,
    output logic [WIDTH-1:0]   count,
    output logic               count_tc,
    output logic               done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    cnt_state_e       state_q;
    cnt_state_e       state_d;
    logic             done_q;
    logic             done_d;

    cnt_mode_e        mode_e;
    logic             oneshot;
    logic             start_eff;
    logic             active;
    logic             en_eff;
    logic [WIDTH-1:0] target;
    logic             at_target;
    logic [WIDTH-1:0] preset;

    assign mode_e    = decode_mode(mode);
    assign oneshot   = (mode_e == CNT_ONESHOT);
    assign start_eff = start && oneshot;
    assign active    = !oneshot || (state_q == ST_RUN);
    assign target    = up_dn ? term_val : '0;
    assign at_target = (count_q == target);
    assign preset    = up_dn ? '0 : term_val;

`ifdef COUNTER_PRESCALE_EN
    logic presc_tick;

    counter_prescaler u_prescaler (
        .clock (clock),
        .reset (reset),
        .clr   (load || start_eff),
        .en_in (count_en),
        .div   (presc_div),
        .tick  (presc_tick)
    );

    assign en_eff = presc_tick;
`else
    assign en_eff = count_en;
`endif

    // Left combinational so a downstream counter can use it as its enable.
    assign count_tc = en_eff && active && at_target;

    always_comb begin
        count_d = count_q;
        state_d = state_q;
        done_d  = done_q;

        if (!oneshot) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end

        if (load) begin
            count_d = load_val;
        end else if (start_eff) begin
            count_d = preset;
            state_d = ST_RUN;
            done_d  = 1'b0;
        end else if (en_eff && active) begin
            if (!at_target) begin
                count_d = up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end else begin
                case (mode_e)
                    CNT_SAT: begin
                        count_d = count_q;
                    end
                    CNT_ONESHOT: begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                    default: begin
                        count_d = preset;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= RESET_VAL;
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign done  = done_q;

endmodule
